axil_rd_arbiter: RTL and testbench

Two-requester AXI4-Lite read arbiter that shares the single instruction ROM read port between the instruction-fetch unit (requester 0) and the load path (requester 1, constant/rodata loads). It sits between the core's two AXI-Lite read masters and the ROM slave. It accepts one transaction at a time, grants round-robin, and routes the ROM response back to the granted requester. Reads only; no write channels.

---
 rtl/axil_rd_arbiter.sv | 131 +++++++++++++
 tb/tb_axil_rd_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_rd_arbiter.sv
// Round-robin AXI4-Lite read arbiter: two requesters share one ROM read port.
// One transaction in flight; the response is routed back to the granted requester.
module axil_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] i_s0_axil_araddr,
    input  logic                  i_s0_axil_arvalid,
    output logic                  o_s0_axil_arready,
    output logic [DATA_WIDTH-1:0] o_s0_axil_rdata,
    output logic                  o_s0_axil_rvalid,
    input  logic                  i_s0_axil_rready,
    input  logic [ADDR_WIDTH-1:0] i_s1_axil_araddr,
    input  logic                  i_s1_axil_arvalid,
    output logic                  o_s1_axil_arready,
    output logic [DATA_WIDTH-1:0] o_s1_axil_rdata,
    output logic                  o_s1_axil_rvalid,
    input  logic                  i_s1_axil_rready,
    output logic [ADDR_WIDTH-1:0] o_m_axil_araddr,
    output logic                  o_m_axil_arvalid,
    input  logic                  i_m_axil_arready,
    input  logic [DATA_WIDTH-1:0] i_m_axil_rdata,
    input  logic                  i_m_axil_rvalid,
    output logic                  o_m_axil_rready,
    output logic [1:0]            o_grant
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both 1;
    // valid, once raised, holds with its payload stable until that cycle.

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e                state_q, state_d;
    logic                  last_q, last_d;
    logic [1:0]            grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic                  pick_s1;
    logic                  gnt_s1;

    assign o_m_axil_araddr  = araddr_q;
    assign o_m_axil_arvalid = arvalid_q;
    assign o_grant          = grant_q;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;

        o_s0_axil_arready = 1'b0;
        o_s1_axil_arready = 1'b0;
        o_s0_axil_rvalid  = 1'b0;
        o_s1_axil_rvalid  = 1'b0;
        o_s0_axil_rdata   = '0;
        o_s1_axil_rdata   = '0;
        o_m_axil_rready   = 1'b0;

        // On a tie, the requester that was not served last wins.
        pick_s1 = i_s1_axil_arvalid && (!i_s0_axil_arvalid || !last_q);
        gnt_s1  = grant_q[1];

        case (state_q)
            IDLE: begin
                o_m_axil_rready = 1'b1;
                if (i_s0_axil_arvalid || i_s1_axil_arvalid) begin
                    o_s0_axil_arready = !pick_s1;
                    o_s1_axil_arready = pick_s1;
                    araddr_d  = pick_s1 ? i_s1_axil_araddr : i_s0_axil_araddr;
                    arvalid_d = 1'b1;
                    grant_d   = pick_s1 ? 2'b10 : 2'b01;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (i_m_axil_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (gnt_s1) begin
                    o_s1_axil_rvalid = i_m_axil_rvalid;
                    o_s1_axil_rdata  = i_m_axil_rdata;
                    o_m_axil_rready  = i_s1_axil_rready;
                end else begin
                    o_s0_axil_rvalid = i_m_axil_rvalid;
                    o_s0_axil_rdata  = i_m_axil_rdata;
                    o_m_axil_rready  = i_s0_axil_rready;
                end
                if (i_m_axil_rvalid && o_m_axil_rready) begin
                    last_d  = gnt_s1;
                    grant_d = 2'b00;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // No handshake may be offered in a cycle whose state is being discarded.
        if (reset) begin
            o_s0_axil_arready = 1'b0;
            o_s1_axil_arready = 1'b0;
            o_s0_axil_rvalid  = 1'b0;
            o_s1_axil_rvalid  = 1'b0;
            o_s0_axil_rdata   = '0;
            o_s1_axil_rdata   = '0;
            o_m_axil_rready   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            grant_q   <= 2'b00;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
        end
    end

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Directed bench for axil_rd_arbiter: per-cycle vector table plus a few
// hand-written reads with random ROM wait states checked against a queue.
module tb_axil_rd_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] s0_araddr, s1_araddr;
    logic        s0_arvalid, s1_arvalid;
    logic        s0_arready, s1_arready;
    logic [31:0] s0_rdata, s1_rdata;
    logic        s0_rvalid, s1_rvalid;
    logic        s0_rready, s1_rready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic        m_rvalid;
    logic        m_rready;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    axil_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .i_s0_axil_araddr  (s0_araddr),
        .i_s0_axil_arvalid (s0_arvalid),
        .o_s0_axil_arready (s0_arready),
        .o_s0_axil_rdata   (s0_rdata),
        .o_s0_axil_rvalid  (s0_rvalid),
        .i_s0_axil_rready  (s0_rready),
        .i_s1_axil_araddr  (s1_araddr),
        .i_s1_axil_arvalid (s1_arvalid),
        .o_s1_axil_arready (s1_arready),
        .o_s1_axil_rdata   (s1_rdata),
        .o_s1_axil_rvalid  (s1_rvalid),
        .i_s1_axil_rready  (s1_rready),
        .o_m_axil_araddr   (m_araddr),
        .o_m_axil_arvalid  (m_arvalid),
        .i_m_axil_arready  (m_arready),
        .i_m_axil_rdata    (m_rdata),
        .i_m_axil_rvalid   (m_rvalid),
        .o_m_axil_rready   (m_rready),
        .o_grant           (grant)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        s0v;
        logic [31:0] s0a;
        logic        s1v;
        logic [31:0] s1a;
        logic        s0rr;
        logic        s1rr;
        logic        marr;
        logic        mrv;
        logic [31:0] mrd;
        logic        e_s0ar;
        logic        e_s1ar;
        logic        e_s0rv;
        logic [31:0] e_s0rd;
        logic        e_s1rv;
        logic [31:0] e_s1rd;
        logic        e_mav;
        logic [31:0] e_maa;
        logic        e_mrr;
        logic [1:0]  e_gnt;
    } vec_t;

    vec_t vecs[$];
    vec_t cur;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // vector inputs for one cycle
    task automatic vi(input logic [31:0] rst, input logic [31:0] s0v, input logic [31:0] s0a,
                      input logic [31:0] s1v, input logic [31:0] s1a, input logic [31:0] s0rr,
                      input logic [31:0] s1rr, input logic [31:0] marr, input logic [31:0] mrv,
                      input logic [31:0] mrd);
        cur.rst  = rst[0];
        cur.s0v  = s0v[0];
        cur.s0a  = s0a;
        cur.s1v  = s1v[0];
        cur.s1a  = s1a;
        cur.s0rr = s0rr[0];
        cur.s1rr = s1rr[0];
        cur.marr = marr[0];
        cur.mrv  = mrv[0];
        cur.mrd  = mrd;
    endtask

    // expected outputs observed during that same cycle, then push the record
    task automatic ve(input logic [31:0] s0ar, input logic [31:0] s1ar, input logic [31:0] s0rv,
                      input logic [31:0] s0rd, input logic [31:0] s1rv, input logic [31:0] s1rd,
                      input logic [31:0] mav, input logic [31:0] maa, input logic [31:0] mrr,
                      input logic [31:0] gnt);
        cur.e_s0ar = s0ar[0];
        cur.e_s1ar = s1ar[0];
        cur.e_s0rv = s0rv[0];
        cur.e_s0rd = s0rd;
        cur.e_s1rv = s1rv[0];
        cur.e_s1rd = s1rd;
        cur.e_mav  = mav[0];
        cur.e_maa  = maa;
        cur.e_mrr  = mrr[0];
        cur.e_gnt  = gnt[1:0];
        vecs.push_back(cur);
    endtask

    task automatic drive_idle();
        reset      = 1'b0;
        s0_arvalid = 1'b0;
        s0_araddr  = '0;
        s1_arvalid = 1'b0;
        s1_araddr  = '0;
        s0_rready  = 1'b0;
        s1_rready  = 1'b0;
        m_arready  = 1'b0;
        m_rvalid   = 1'b0;
        m_rdata    = '0;
    endtask

    task automatic apply_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        @(negedge clk);
        reset      = v.rst;
        s0_arvalid = v.s0v;
        s0_araddr  = v.s0a;
        s1_arvalid = v.s1v;
        s1_araddr  = v.s1a;
        s0_rready  = v.s0rr;
        s1_rready  = v.s1rr;
        m_arready  = v.marr;
        m_rvalid   = v.mrv;
        m_rdata    = v.mrd;
        #1;
        chk("s0_arready", idx, 32'(s0_arready), 32'(v.e_s0ar));
        chk("s1_arready", idx, 32'(s1_arready), 32'(v.e_s1ar));
        chk("s0_rvalid",  idx, 32'(s0_rvalid),  32'(v.e_s0rv));
        chk("s0_rdata",   idx, s0_rdata,        v.e_s0rd);
        chk("s1_rvalid",  idx, 32'(s1_rvalid),  32'(v.e_s1rv));
        chk("s1_rdata",   idx, s1_rdata,        v.e_s1rd);
        chk("m_arvalid",  idx, 32'(m_arvalid),  32'(v.e_mav));
        chk("m_araddr",   idx, m_araddr,        v.e_maa);
        chk("m_rready",   idx, 32'(m_rready),   32'(v.e_mrr));
        chk("grant",      idx, 32'(grant),      32'(v.e_gnt));
    endtask

    // One read through requester req with random ROM address/data wait states.
    task automatic rd_seq(input int req, input logic [31:0] addr, input logic [31:0] data);
        int n;
        int waits;
        int dly;
        logic arr;
        @(negedge clk);
        s0_rready = 1'b1;
        s1_rready = 1'b1;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        if (req == 0) begin
            s0_arvalid = 1'b1;
            s0_araddr  = addr;
        end else begin
            s1_arvalid = 1'b1;
            s1_araddr  = addr;
        end
        #1;
        n = 0;
        arr = (req == 0) ? s0_arready : s1_arready;
        while (!arr && n < 20) begin
            @(negedge clk);
            #1;
            arr = (req == 0) ? s0_arready : s1_arready;
            n++;
        end
        chk("seq_arready", req, 32'(arr), 32'd1);
        @(negedge clk);
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
        waits = $urandom_range(0, 3);
        for (int w = 0; w < waits; w++) begin
            #1;
            chk("seq_hold_araddr", w, m_araddr, addr);
            chk("seq_hold_arvalid", w, 32'(m_arvalid), 32'd1);
            @(negedge clk);
        end
        m_arready = 1'b1;
        #1;
        chk("seq_arvalid", req, 32'(m_arvalid), 32'd1);
        @(negedge clk);
        m_arready = 1'b0;
        dly = $urandom_range(0, 3);
        for (int d = 0; d < dly; d++) begin
            #1;
            chk("seq_no_rvalid", d, 32'(s0_rvalid | s1_rvalid), 32'd0);
            @(negedge clk);
        end
        m_rvalid = 1'b1;
        m_rdata  = data;
        exp_q.push_back(data);
        #1;
        if (req == 0) begin
            chk("seq_rvalid", req, 32'(s0_rvalid), 32'd1);
            chk("seq_rdata", req, s0_rdata, exp_q.pop_front());
            chk("seq_other_rvalid", req, 32'(s1_rvalid), 32'd0);
        end else begin
            chk("seq_rvalid", req, 32'(s1_rvalid), 32'd1);
            chk("seq_rdata", req, s1_rdata, exp_q.pop_front());
            chk("seq_other_rvalid", req, 32'(s0_rvalid), 32'd0);
        end
        @(negedge clk);
        m_rvalid = 1'b0;
        #1;
        chk("seq_grant_idle", req, 32'(grant), 32'd0);
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // reset state
        vi(0,0,0,0,0,0,0,0,0,0);               ve(0,0,0,0,0,0,0,0,1,0);
        // single fetch from s0
        vi(0,1,'h10,0,0,0,0,1,0,0);            ve(1,0,0,0,0,0,0,0,1,0);
        vi(0,0,0,0,0,0,0,1,0,0);               ve(0,0,0,0,0,0,1,'h10,0,1);
        vi(0,0,0,0,0,1,0,1,1,'hDEADBEEF);      ve(0,0,1,'hDEADBEEF,0,0,0,'h10,1,1);
        vi(0,0,0,0,0,0,0,0,0,0);               ve(0,0,0,0,0,0,0,'h10,1,0);
        // reset: last back to 1, araddr cleared
        vi(1,0,0,0,0,0,0,0,0,0);               ve(0,0,0,0,0,0,0,'h10,1,0);
        // both held valid: s0, s1, s0, s1
        vi(0,1,'h4,1,'h8,1,1,1,0,0);           ve(1,0,0,0,0,0,0,0,1,0);
        vi(0,1,'h4,1,'h8,1,1,1,0,0);           ve(0,0,0,0,0,0,1,'h4,0,1);
        vi(0,1,'h4,1,'h8,1,1,1,1,'h1004);      ve(0,0,1,'h1004,0,0,0,'h4,1,1);
        vi(0,1,'h4,1,'h8,1,1,1,0,0);           ve(0,1,0,0,0,0,0,'h4,1,0);
        vi(0,1,'h4,1,'h8,1,1,1,0,0);           ve(0,0,0,0,0,0,1,'h8,0,2);
        vi(0,1,'h4,1,'h8,1,1,1,1,'h1008);      ve(0,0,0,0,1,'h1008,0,'h8,1,2);
        vi(0,1,'h4,1,'h8,1,1,1,0,0);           ve(1,0,0,0,0,0,0,'h8,1,0);
        vi(0,1,'h4,1,'h8,1,1,1,0,0);           ve(0,0,0,0,0,0,1,'h4,0,1);
        vi(0,1,'h4,1,'h8,1,1,1,1,'h1004);      ve(0,0,1,'h1004,0,0,0,'h4,1,1);
        vi(0,1,'h4,1,'h8,1,1,1,0,0);           ve(0,1,0,0,0,0,0,'h4,1,0);
        vi(0,1,'h4,1,'h8,1,1,1,0,0);           ve(0,0,0,0,0,0,1,'h8,0,2);
        vi(0,1,'h4,1,'h8,1,1,1,1,'h1008);      ve(0,0,0,0,1,'h1008,0,'h8,1,2);
        vi(0,0,0,0,0,0,0,0,0,0);               ve(0,0,0,0,0,0,0,'h8,1,0);
        // ROM address stall for 4 cycles
        vi(0,1,'h30,0,0,1,0,0,0,0);            ve(1,0,0,0,0,0,0,'h8,1,0);
        vi(0,0,0,0,0,1,0,0,0,0);               ve(0,0,0,0,0,0,1,'h30,0,1);
        vi(0,0,0,0,0,1,0,0,0,0);               ve(0,0,0,0,0,0,1,'h30,0,1);
        vi(0,0,0,0,0,1,0,0,0,0);               ve(0,0,0,0,0,0,1,'h30,0,1);
        vi(0,0,0,0,0,1,0,0,0,0);               ve(0,0,0,0,0,0,1,'h30,0,1);
        vi(0,0,0,0,0,1,0,1,0,0);               ve(0,0,0,0,0,0,1,'h30,0,1);
        vi(0,0,0,0,0,1,0,0,1,'h3333);          ve(0,0,1,'h3333,0,0,0,'h30,1,1);
        vi(0,0,0,0,0,0,0,0,0,0);               ve(0,0,0,0,0,0,0,'h30,1,0);
        // s1 wins the tie, then stalls on rready for 3 cycles; s0 waits
        vi(0,1,'h40,1,'h44,0,0,1,0,0);         ve(0,1,0,0,0,0,0,'h30,1,0);
        vi(0,1,'h40,0,0,0,0,1,0,0);            ve(0,0,0,0,0,0,1,'h44,0,2);
        vi(0,1,'h40,0,0,0,0,1,1,'h4444);       ve(0,0,0,0,1,'h4444,0,'h44,0,2);
        vi(0,1,'h40,0,0,0,0,1,1,'h4444);       ve(0,0,0,0,1,'h4444,0,'h44,0,2);
        vi(0,1,'h40,0,0,0,0,1,1,'h4444);       ve(0,0,0,0,1,'h4444,0,'h44,0,2);
        vi(0,1,'h40,0,0,0,1,1,1,'h4444);       ve(0,0,0,0,1,'h4444,0,'h44,1,2);
        vi(0,1,'h40,0,0,1,0,1,0,0);            ve(1,0,0,0,0,0,0,'h44,1,0);
        vi(0,0,0,0,0,1,0,1,0,0);               ve(0,0,0,0,0,0,1,'h40,0,1);
        vi(0,0,0,0,0,1,0,1,1,'h4040);          ve(0,0,1,'h4040,0,0,0,'h40,1,1);
        vi(0,0,0,0,0,0,0,0,0,0);               ve(0,0,0,0,0,0,0,'h40,1,0);
        // reset while waiting for ROM data; late response is drained
        vi(0,1,'h50,0,0,1,0,1,0,0);            ve(1,0,0,0,0,0,0,'h40,1,0);
        vi(0,0,0,0,0,1,0,1,0,0);               ve(0,0,0,0,0,0,1,'h50,0,1);
        vi(0,0,0,0,0,1,0,1,0,0);               ve(0,0,0,0,0,0,0,'h50,1,1);
        vi(1,0,0,0,0,1,0,1,0,0);               ve(0,0,0,0,0,0,0,'h50,1,1);
        vi(0,0,0,0,0,1,1,1,1,'hBAD0BAD0);      ve(0,0,0,0,0,0,0,0,1,0);
        vi(0,0,0,1,'h58,1,1,1,0,0);            ve(0,1,0,0,0,0,0,0,1,0);
        vi(0,0,0,0,0,1,1,1,0,0);               ve(0,0,0,0,0,0,1,'h58,0,2);
        vi(0,0,0,0,0,1,1,1,1,'h5858);          ve(0,0,0,0,1,'h5858,0,'h58,1,2);
        vi(0,0,0,0,0,0,0,0,0,0);               ve(0,0,0,0,0,0,0,'h58,1,0);
        // s1 pulses arvalid for one cycle while s0 owns the port
        vi(0,1,'h60,0,0,1,0,0,0,0);            ve(1,0,0,0,0,0,0,'h58,1,0);
        vi(0,0,0,1,'h64,1,0,0,0,0);            ve(0,0,0,0,0,0,1,'h60,0,1);
        vi(0,0,0,0,0,1,0,1,0,0);               ve(0,0,0,0,0,0,1,'h60,0,1);
        vi(0,0,0,0,0,1,0,0,1,'h6060);          ve(0,0,1,'h6060,0,0,0,'h60,1,1);
        vi(0,0,0,0,0,0,0,0,0,0);               ve(0,0,0,0,0,0,0,'h60,1,0);
        vi(0,0,0,0,0,0,0,0,0,0);               ve(0,0,0,0,0,0,0,'h60,1,0);

        for (int i = 0; i < vecs.size(); i++) apply_vec(i);

        drive_idle();
        for (int k = 0; k < 4; k++) begin
            rd_seq(k % 2, 32'h100 + 32'(k * 4), $urandom);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
